// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - round-robin arbiter sharing one synchronous RAM between two requesters
//
// Purpose:
//   Two client ports each raise req with we/addr/wdata held stable until their
//   one-cycle ack. The arbiter grants one port at a time and latches that
//   port's operation. It drives the RAM for exactly one ACCESS cycle. A read
//   spends one extra cycle in RDWAIT so the registered RAM output can be
//   captured into the granted port's rdata.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req0/1, we0/1            request and write(1)/read(0) select per port
//   addr0/1, wdata0/1        word address and write data per port
//   ack0/1                   one-cycle completion pulse per port
//   rdata0/1                 last read result per port, held between reads
//   busy                     high whenever the arbiter is not idle
//   ram_address, ram_data_in RAM address / write data (latched operation)
//   ram_write_enable         RAM write strobe, ACCESS cycle of a write only
//   ram_read_enable          RAM read strobe, ACCESS cycle of a read only
//   ram_data_out             RAM registered read data

module ram_access_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write_enable,
    output logic                  ram_read_enable,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t                state_q,    state_d;
    logic                  ptr_q,      ptr_d;      // port that wins the next contested round
    logic                  op_we_q,    op_we_d;
    logic [ADDR_WIDTH-1:0] op_addr_q,  op_addr_d;
    logic [DATA_WIDTH-1:0] op_wdata_q, op_wdata_d;
    logic                  op_port_q,  op_port_d;  // granted port id
    logic                  ack0_q,     ack0_d;
    logic                  ack1_q,     ack1_d;
    logic [DATA_WIDTH-1:0] rdata0_q,   rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q,   rdata1_d;

    // Port 1 wins when it is the only requester, or when both request and
    // the pointer favours it.
    logic grant1;
    assign grant1 = req1 && (!req0 || ptr_q);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        op_we_d    = op_we_q;
        op_addr_d  = op_addr_q;
        op_wdata_d = op_wdata_q;
        op_port_d  = op_port_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    op_port_d  = grant1;
                    op_we_d    = grant1 ? we1    : we0;
                    op_addr_d  = grant1 ? addr1  : addr0;
                    op_wdata_d = grant1 ? wdata1 : wdata0;
                    // The loser gets priority next time, so neither port starves.
                    ptr_d      = ~grant1;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (op_we_q) begin
                    state_d = ST_IDLE;
                    if (op_port_q) begin
                        ack1_d = 1'b1;
                    end else begin
                        ack0_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                // RAM output registered during ACCESS is valid now.
                state_d = ST_IDLE;
                if (op_port_q) begin
                    rdata1_d = ram_data_out;
                    ack1_d   = 1'b1;
                end else begin
                    rdata0_d = ram_data_out;
                    ack0_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            op_we_q    <= 1'b0;
            op_addr_q  <= '0;
            op_wdata_q <= '0;
            op_port_q  <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            op_we_q    <= op_we_d;
            op_addr_q  <= op_addr_d;
            op_wdata_q <= op_wdata_d;
            op_port_q  <= op_port_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Address/data simply hold the latched operation; only the strobes are
    // qualified by state, so they are mutually exclusive by construction.
    assign ram_address      = op_addr_q;
    assign ram_data_in      = op_wdata_q;
    assign ram_write_enable = (state_q == ST_ACCESS) &&  op_we_q;
    assign ram_read_enable  = (state_q == ST_ACCESS) && !op_we_q;
    assign busy             = (state_q != ST_IDLE);
    assign ack0             = ack0_q;
    assign ack1             = ack1_q;
    assign rdata0           = rdata0_q;
    assign rdata1           = rdata1_q;

endmodule
